// File: rtl/sc_regshifter_seq_pkg.sv
// Shared encodings for the sequenced multi-mode shift register:
// shift modes and controller states.
package sc_regshifter_seq_pkg;

   typedef enum logic [2:0] {
      MODE_LSL = 3'b000,
      MODE_LSR = 3'b001,
      MODE_ASR = 3'b010,
      MODE_ROL = 3'b011,
      MODE_ROR = 3'b100,
      MODE_SIL = 3'b101,
      MODE_SIR = 3'b110,
      MODE_RES = 3'b111
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   // Left-moving modes eject the MSB, right-moving modes the LSB.
   function automatic logic is_left(input mode_t m);
      return (m == MODE_LSL) || (m == MODE_ROL) || (m == MODE_SIL);
   endfunction

endpackage

// File: rtl/sc_regshifter_seq_shift1.sv
// Single-position combinational shifter: computes the next register value
// and the ejected bit for one step in the selected mode.
module sc_shift1_unit
   import sc_regshifter_seq_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] data,
   input  mode_t        mode,
   input  logic         serial_in,
   output logic [W-1:0] next_data,
   output logic         eject,
   output logic         eject_vld
);

   always_comb begin
      next_data = data;
      eject     = 1'b0;
      eject_vld = 1'b1;
      case (mode)
         MODE_LSL: next_data = {data[W-2:0], 1'b0};
         MODE_LSR: next_data = {1'b0, data[W-1:1]};
         MODE_ASR: next_data = {data[W-1], data[W-1:1]};
         MODE_ROL: next_data = {data[W-2:0], data[W-1]};
         MODE_ROR: next_data = {data[0], data[W-1:1]};
         MODE_SIL: next_data = {data[W-2:0], serial_in};
         MODE_SIR: next_data = {serial_in, data[W-1:1]};
         default: begin
            next_data = data;
            eject_vld = 1'b0;
         end
      endcase
      if (eject_vld)
         eject = is_left(mode) ? data[W-1] : data[0];
   end

endmodule

// File: rtl/sc_regshifter_seq.sv
// Sequenced shift register: a start request shifts the register by the
// requested count, one bit position per clock, then pulses done.
module sc_regshifter_seq
   import sc_regshifter_seq_pkg::*;
#(
   parameter int RegSHIFTER_DATAWIDTH  = 8,
   parameter int RegSHIFTER_COUNTWIDTH = 4
) (
   input  logic                             SC_RegSHIFTERSEQ_CLOCK_50,
   input  logic                             SC_RegSHIFTERSEQ_RESET_InLow,
   input  logic                             SC_RegSHIFTERSEQ_clear_InLow,
   input  logic                             SC_RegSHIFTERSEQ_load_InLow,
   input  logic                             SC_RegSHIFTERSEQ_start_In,
   input  logic [2:0]                       SC_RegSHIFTERSEQ_mode_In,
   input  logic [RegSHIFTER_COUNTWIDTH-1:0] SC_RegSHIFTERSEQ_count_In,
   input  logic                             SC_RegSHIFTERSEQ_serial_In,
   input  logic [RegSHIFTER_DATAWIDTH-1:0]  SC_RegSHIFTERSEQ_data_InBUS,
   output logic [RegSHIFTER_DATAWIDTH-1:0]  SC_RegSHIFTERSEQ_data_OutBUS,
   output logic                             SC_RegSHIFTERSEQ_serial_Out,
   output logic                             SC_RegSHIFTERSEQ_busy_Out,
   output logic                             SC_RegSHIFTERSEQ_done_Out
);

   localparam int W  = RegSHIFTER_DATAWIDTH;
   localparam int CW = RegSHIFTER_COUNTWIDTH;

   state_t          state;
   mode_t           mode_q;
   logic [CW-1:0]   remaining;
   logic [W-1:0]    shreg;
   logic            sout;
   logic            busy;
   logic            done;

   logic [W-1:0]    step_data;
   logic            step_eject;
   logic            step_eject_vld;

   sc_shift1_unit #(.W(W)) u_shift1 (
      .data      (shreg),
      .mode      (mode_q),
      .serial_in (SC_RegSHIFTERSEQ_serial_In),
      .next_data (step_data),
      .eject     (step_eject),
      .eject_vld (step_eject_vld)
   );

   always_ff @(posedge SC_RegSHIFTERSEQ_CLOCK_50 or negedge SC_RegSHIFTERSEQ_RESET_InLow) begin
      if (!SC_RegSHIFTERSEQ_RESET_InLow) begin
         state     <= ST_IDLE;
         mode_q    <= MODE_LSL;
         remaining <= '0;
         shreg     <= '0;
         sout      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (!SC_RegSHIFTERSEQ_clear_InLow) begin
                  shreg <= '0;
                  sout  <= 1'b0;
               end else if (!SC_RegSHIFTERSEQ_load_InLow) begin
                  shreg <= SC_RegSHIFTERSEQ_data_InBUS;
               end else if (SC_RegSHIFTERSEQ_start_In) begin
                  mode_q <= mode_t'(SC_RegSHIFTERSEQ_mode_In);
                  if (SC_RegSHIFTERSEQ_count_In == '0) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     remaining <= SC_RegSHIFTERSEQ_count_In;
                     state     <= ST_SHIFT;
                     busy      <= 1'b1;
                  end
               end
            end
            ST_SHIFT: begin
               if (!SC_RegSHIFTERSEQ_clear_InLow) begin
                  // Abort: the sequence ends silently, without a done pulse.
                  shreg <= '0;
                  sout  <= 1'b0;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  shreg <= step_data;
                  if (step_eject_vld)
                     sout <= step_eject;
                  remaining <= remaining - CW'(1);
                  if (remaining == CW'(1)) begin
                     state <= ST_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
               if (!SC_RegSHIFTERSEQ_clear_InLow) begin
                  shreg <= '0;
                  sout  <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   assign SC_RegSHIFTERSEQ_data_OutBUS = shreg;
   assign SC_RegSHIFTERSEQ_serial_Out  = sout;
   assign SC_RegSHIFTERSEQ_busy_Out    = busy;
   assign SC_RegSHIFTERSEQ_done_Out    = done;

endmodule

// File: tb/tb_sc_regshifter_seq.sv
// Scoreboard bench for sc_regshifter_seq: stimulus pushes expected results
// from an arithmetic reference model; a monitor checks them on each done.
module tb_sc_regshifter_seq;

   localparam int W  = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clear_n, load_n, start, serial_i;
   logic [2:0]    mode;
   logic [CW-1:0] count;
   logic [W-1:0]  din;
   logic [W-1:0]  dout;
   logic          serial_o, busy, done;

   always #5 clk = ~clk;

   sc_regshifter_seq #(.RegSHIFTER_DATAWIDTH(W), .RegSHIFTER_COUNTWIDTH(CW)) dut (
      .SC_RegSHIFTERSEQ_CLOCK_50    (clk),
      .SC_RegSHIFTERSEQ_RESET_InLow (rst_n),
      .SC_RegSHIFTERSEQ_clear_InLow (clear_n),
      .SC_RegSHIFTERSEQ_load_InLow  (load_n),
      .SC_RegSHIFTERSEQ_start_In    (start),
      .SC_RegSHIFTERSEQ_mode_In     (mode),
      .SC_RegSHIFTERSEQ_count_In    (count),
      .SC_RegSHIFTERSEQ_serial_In   (serial_i),
      .SC_RegSHIFTERSEQ_data_InBUS  (din),
      .SC_RegSHIFTERSEQ_data_OutBUS (dout),
      .SC_RegSHIFTERSEQ_serial_Out  (serial_o),
      .SC_RegSHIFTERSEQ_busy_Out    (busy),
      .SC_RegSHIFTERSEQ_done_Out    (done)
   );

   typedef struct {
      int data;
      int sout;
      int steps;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   mreg   = 0;
   int   msout  = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: one step expressed as plain integer arithmetic on the value.
   task automatic mstep(input int m, input int si);
      int full, half, msb, lsb;
      full = 1 << W;
      half = 1 << (W - 1);
      msb  = mreg / half;
      lsb  = mreg % 2;
      case (m)
         0: begin mreg = (mreg * 2) % full;               msout = msb; end
         1: begin mreg = mreg / 2;                        msout = lsb; end
         2: begin mreg = mreg / 2 + msb * half;           msout = lsb; end
         3: begin mreg = (mreg * 2) % full + msb;         msout = msb; end
         4: begin mreg = mreg / 2 + lsb * half;           msout = lsb; end
         5: begin mreg = (mreg * 2) % full + si;          msout = msb; end
         6: begin mreg = mreg / 2 + si * half;            msout = lsb; end
         default: ;
      endcase
   endtask

   task automatic do_load(input logic [W-1:0] v);
      @(negedge clk);
      load_n = 1'b0;
      din    = v;
      @(posedge clk); #1;
      load_n = 1'b1;
      mreg   = int'(v);
   endtask

   task automatic issue(input int m, input int n, input logic [15:0] bits,
                        input logic hold_start, input logic load_during);
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      mode  = 3'(m);
      count = CW'(n);
      for (int k = 0; k < n; k++) mstep(m, int'(bits[k]));
      e.data  = mreg;
      e.sout  = msout;
      e.steps = n;
      q.push_back(e);
      @(posedge clk); #1;
      // Garbage on mode/count after acceptance must be ignored.
      mode  = 3'($urandom_range(0, 7));
      count = CW'($urandom_range(0, 15));
      if (!hold_start) start = 1'b0;
      if (load_during) begin
         load_n = 1'b0;
         din    = W'($urandom);
      end
      for (int k = 0; k < n; k++) begin
         serial_i = bits[k];
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      start  = 1'b0;
      load_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; clear_n = 1'b1; load_n = 1'b1; start = 1'b0;
      serial_i = 1'b0; mode = '0; count = '0; din = '0;
      #12;
      chk("reset_data", int'(dout), 0);
      chk("reset_sout", int'(serial_o), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      @(negedge clk);
      rst_n = 1'b1;

      fork
         begin : monitor
            int  busy_cnt = 0;
            logic prev_done = 1'b0;
            exp_t e;
            forever begin
               @(negedge clk);
               if (busy) busy_cnt++;
               if (done) begin
                  if (prev_done) chk("done_single_pulse", 1, 0);
                  if (q.size() == 0) begin
                     chk("done_unexpected", 1, 0);
                  end else begin
                     e = q.pop_front();
                     chk("data", int'(dout), e.data);
                     chk("serial_out", int'(serial_o), e.sout);
                     chk("busy_cycles", busy_cnt, e.steps);
                  end
               end
               if (!busy && !done) busy_cnt = 0;
               prev_done = done;
            end
         end
         begin : stimulus
            // Directed cases.
            do_load(8'hB5); issue(0, 3, 16'h0000, 1'b0, 1'b0);
            do_load(8'h90); issue(2, 2, 16'h0000, 1'b0, 1'b0);
            do_load(8'h90); issue(1, 2, 16'h0000, 1'b0, 1'b0);
            do_load(8'h3C); issue(3, 8, 16'h0000, 1'b0, 1'b0);
            issue(4, 10, 16'h0000, 1'b0, 1'b0);
            do_load(8'h00); issue(5, 4, 16'h000D, 1'b0, 1'b0);
            issue(6, 5, 16'h0015, 1'b0, 1'b0);
            issue(7, 6, 16'h0000, 1'b0, 1'b0);
            issue(0, 0, 16'h0000, 1'b1, 1'b0);
            do_load(8'hC3); issue(3, 2, 16'h0000, 1'b1, 1'b1);

            // Clear on the second SHIFT cycle aborts; load there is ignored.
            do_load(8'h5A);
            @(negedge clk);
            start = 1'b1; mode = 3'd3; count = CW'(5);
            @(posedge clk); #1;
            start = 1'b0; load_n = 1'b0; din = 8'hFF;
            @(posedge clk); #1;
            clear_n = 1'b0;
            @(posedge clk); #1;
            chk("abort_data", int'(dout), 0);
            chk("abort_sout", int'(serial_o), 0);
            chk("abort_busy", int'(busy), 0);
            clear_n = 1'b1; load_n = 1'b1;
            mreg = 0; msout = 0;
            repeat (4) @(posedge clk);

            // Asynchronous reset in the middle of a sequence.
            do_load(8'hE7);
            @(negedge clk);
            start = 1'b1; mode = 3'd4; count = CW'(6);
            @(posedge clk); #1;
            start = 1'b0;
            @(posedge clk); #3;
            rst_n = 1'b0;
            #1;
            chk("async_rst_data", int'(dout), 0);
            chk("async_rst_sout", int'(serial_o), 0);
            chk("async_rst_busy", int'(busy), 0);
            chk("async_rst_done", int'(done), 0);
            @(negedge clk);
            rst_n = 1'b1;
            mreg = 0; msout = 0;
            repeat (2) @(posedge clk);

            // Randomised operations.
            for (int i = 0; i < 60; i++) begin
               if ($urandom_range(0, 1) == 1) do_load(W'($urandom));
               issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                     16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end

            repeat (20) @(posedge clk);
            chk("scoreboard_drained", q.size(), 0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
      join_any
   end

endmodule
